// File: rtl/unpacked_array_port_sink.sv
// ----------------------------------------------------------------------------
// unpacked_array_port_sink
//
// Receive-side FIFO for producers that drive an M-element unpacked array of
// 1-bit logic. Each accepted word is packed (element d[i] -> bit i, d[0] is
// the LSB), stored in a DEPTH-entry first-word-fall-through FIFO and
// presented on a valid/ready output.
//
// Parameters:
//   M      - elements in the input unpacked array / width of q (>= 1)
//   DEPTH  - FIFO entries (power of two, >= 2)
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   in_valid   in   producer offers d
//   in_ready   out  FIFO can accept a word (not full)
//   d          in   logic d [M], unpacked input word
//   out_valid  out  q holds a valid word (not empty)
//   out_ready  in   consumer accepts q
//   q          out  packed head-of-FIFO word
//   level      out  current occupancy, 0..DEPTH
//
// All outputs are functions of registered state only; there is no
// combinational path from in_valid, d or out_ready to any output.
// ----------------------------------------------------------------------------
module unpacked_array_port_sink #(
  parameter int M     = 2,
  parameter int DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           d [M],
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [M-1:0]                   q,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [M-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [M-1:0]  d_packed;
  logic          push;
  logic          pop;

  // Element i of the unpacked input lands on packed bit i; no reversal.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    d_packed = '0;
    for (int i = 0; i < M; i++) begin
      d_packed[i] = d[i];
    end
  end

  // Full/empty come straight from the occupancy register, so the handshake
  // outputs never depend on the opposite side's inputs in the same cycle.
  // A full FIFO therefore refuses a push even when a pop happens that cycle.
  assign in_ready  = (level != FULL_LEVEL);
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // First-word fall-through: the head entry is always on q.
  assign q = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: storage is cleared on reset as well, so q is a defined 0 rather
      // than X while the FIFO is empty after reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      mem[wr_ptr] <= d_packed;
    end
  end

  // Pointers are PW bits wide and wrap from DEPTH-1 to 0 on their own since
  // DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: doc/unpacked_array_port_sink.md
# unpacked_array_port_sink

Receive-side counterpart for modules that drive an unpacked-array output port of the form `q [M]`. It accepts an M-element unpacked array of 1-bit `logic` on its input port, buffers words in a DEPTH-entry FIFO, and presents them as a packed `[M-1:0]` vector on a valid/ready output. It exists as a TMRG test vehicle: it exercises unpacked-array input ports (IEEE 1800-2017 §7.4.2, §23.2.2) together with real sequential state (pointers, occupancy counter, handshakes) that triplication must preserve.

## Interface
- `M`, default 2: number of elements in the input unpacked array, and width of the packed output. Legal range is ≥1.
- `DEPTH`, default 4: FIFO entries. Must be a power of two, ≥2.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: the producer offers `d`.
- `in_ready` output 1: the block can accept a word.
- `d` input `logic d [M]`: unpacked array, elements `d[0]..d[M-1]`.
- `out_valid` output 1: `q` holds a valid word.
- `out_ready` input 1: the consumer accepts `q`.
- `q` output `[M-1:0]`: packed head-of-FIFO word.
- `level` output `[$clog2(DEPTH+1)-1:0]`: current occupancy, 0..DEPTH.

## Operation
- Element mapping: packed bit `i` = unpacked element `d[i]` for every i in 0..M-1. `d[0]` maps to the LSB. There is no reversal.
- Push: `in_valid && in_ready` at a rising edge writes the word to `mem[wr_ptr]`, and `wr_ptr` increments.
- Pop: `out_valid && out_ready` at a rising edge increments `rd_ptr`.
- Pointers are `$clog2(DEPTH)` bits wide and wrap naturally from DEPTH-1 to 0.
- `level` is a registered counter:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- `in_ready` = (`level` != DEPTH). This is combinational from registered state and does not depend on `out_ready`. When full, no push is accepted in that cycle, even if a pop occurs.
- `out_valid` = (`level` != 0).
- `q` = `mem[rd_ptr]`. This is first-word fall-through: the head word is visible while `out_valid` is high.
- `q` is don't-care when `out_valid` is 0, but must not be X after reset. Memory resets to 0.
- Empty with simultaneous push and pop request: only the push occurs, because `out_valid` is 0. `level` becomes 1.
- Full with `in_valid` and `out_ready` both high: only the pop occurs. `level` becomes DEPTH−1, and `in_ready` rises next cycle.
- The input word is ignored whenever `in_valid` is 0 or `in_ready` is 0. Storage and pointers do not change.
- Ordering: strict FIFO, with no reordering or drops under legal handshakes.

## Timing
- Reset values, applied asynchronously on `reset` assertion:
  - `wr_ptr`=0, `rd_ptr`=0, `level`=0, all `mem` entries = 0.
  - Therefore `in_ready`=1, `out_valid`=0, `q`=0.
- Reset release: the first push is possible at the first rising edge after deassertion.
- Reset mid-operation: contents are discarded immediately, and outputs take their reset values within the same cycle (asynchronously).
- Latency: a word pushed at edge k is visible on `q` with `out_valid`=1 after edge k when the FIFO was empty, i.e. 1 cycle.
- Throughput: 1 word/cycle sustained when `out_ready` is held high.
- All outputs are derived from registers only. There is no combinational path from `in_valid`, `d` or `out_ready` to any output.

## Test plan
- Reset check: assert `reset` mid-stream with `level`=3 → `out_valid`=0, `in_ready`=1, `level`=0, `q`=0 immediately, before any clock edge.
- Mapping (M=4): push `d[0]=1, d[1]=0, d[2]=1, d[3]=1` → `q`=4'b1101, `out_valid`=1, one cycle after the push edge.
- Fill/full (DEPTH=4): push 1,2,3,0,1 with `out_ready`=0 → the first four are accepted, `level`=4, `in_ready`=0, and the fifth is not accepted. Then pop four → outputs 1,2,3,0 in order, ending with `level`=0.
- Wrap-around: 10 pushes of incrementing values, with each one popped two cycles later → output order matches input, pointers wrap past 3→0, `level` never exceeds 2.
- Simultaneous events: at `level`=2, `in_valid` and `out_ready` both high for one cycle → `level` stays 2, and the head advances. Repeating this at full → `level`=3 and no write occurs.
- Streaming: `in_valid` and `out_ready` held high for 16 cycles → 16 words out, 1 per cycle, `level` constant at 1 after the first cycle.
